// File: rtl/apb_pkg.sv
// Shared types for the APB completer.
// Default bus widths come from the AW/DW macros. Each falls back to 8 bits
// when the build does not define it.
`ifndef AW
`define AW 8
`endif
`ifndef DW
`define DW 8
`endif

package apb_pkg;

    typedef enum logic {IDLE, ACCESS} apb_slv_state_e;

    typedef logic [`AW-1:0] apb_addr_t;
    typedef logic [`DW-1:0] apb_data_t;

    // Upper bound of the 4-bit wait-state counter.
    localparam int APB_MAX_WAIT = 15;

endpackage

// File: rtl/apb_slave_regfile.sv
// DEPTH x DW storage block for the APB completer.
// Writes are synchronous and reads are combinational.
// A synchronous reset clears every word to zero.
module apb_slave_regfile #(
    parameter int DW    = 8,
    parameter int DEPTH = 64,
    parameter int IW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          we_i,
    input  logic [IW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [IW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];

    // Reset clears all words; otherwise commit a single write.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/apb_slave_mem.sv
// APB completer with a local register-file memory.
// It adds a fixed number of access wait states and flags out-of-range
// addresses with pslverr.
// Optional feature macro: APB_WAIT_STATE_EN. When it is defined, the
// WAIT_CYCLES wait states are honoured. When it is undefined, every
// transfer is zero-wait and takes two cycles.
import apb_pkg::*;

module apb_slave_mem #(
    parameter int AW          = `AW,
    parameter int DW          = `DW,
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic          pclk,
    input  logic          preset,
    input  logic          psel,
    input  logic          penable,
    input  logic          pwrite,
    input  logic [AW-1:0] paddr,
    input  logic [DW-1:0] pwdata,
    output logic          pready,
    output logic [DW-1:0] prdata,
    output logic          pslverr
);

    localparam int IW = $clog2(DEPTH);
`ifdef APB_WAIT_STATE_EN
    localparam int WAIT_EFF = (WAIT_CYCLES > APB_MAX_WAIT) ? APB_MAX_WAIT : WAIT_CYCLES;
`else
    // WAIT_CYCLES stays a parameter so the interface is the same, but it has no effect here.
    localparam int WAIT_EFF = WAIT_CYCLES * 0;
`endif
    localparam bit ZERO_WAIT = (WAIT_EFF == 0);

    apb_slv_state_e state_q;
    logic           pready_q, pslverr_q, wr_q, err_q;
    logic [DW-1:0]  prdata_q, wdata_q;
    logic [IW-1:0]  addr_q;
`ifdef APB_WAIT_STATE_EN
    logic [3:0]     wait_cnt_q;
`endif

    logic           setup_go, setup_err, we_d;
    logic [IW-1:0]  rd_idx;
    logic [DW-1:0]  rd_data;

    // Setup can arrive in IDLE, or mid-ACCESS as a fresh transfer that drops the old one.
    assign setup_go  = psel && !penable;
    // The range check uses every address bit; only the low bits index the memory.
    assign setup_err = ({1'b0, paddr} >= (AW+1)'(DEPTH));

    // A zero-wait read samples memory at the setup edge, so it reads at the live address.
    assign rd_idx = ZERO_WAIT ? paddr[IW-1:0] : addr_q;

    // Commit on the completion edge only. Abandoned, aborted or errored transfers never write.
    assign we_d = (state_q == ACCESS) && psel && penable && pready_q && wr_q && !err_q;

    apb_slave_regfile #(.DW(DW), .DEPTH(DEPTH), .IW(IW)) u_regfile (
        .clk_i   (pclk),
        .rst_i   (preset),
        .we_i    (we_d),
        .waddr_i (addr_q),
        .wdata_i (wdata_q),
        .raddr_i (rd_idx),
        .rdata_o (rd_data)
    );

    // Transfer FSM, wait counter and registered response.
    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q    <= IDLE;
            pready_q   <= 1'b0;
            pslverr_q  <= 1'b0;
            prdata_q   <= '0;
            addr_q     <= '0;
            wr_q       <= 1'b0;
            wdata_q    <= '0;
            err_q      <= 1'b0;
`ifdef APB_WAIT_STATE_EN
            wait_cnt_q <= '0;
`endif
        end else if (setup_go) begin
            state_q    <= ACCESS;
            addr_q     <= paddr[IW-1:0];
            wr_q       <= pwrite;
            wdata_q    <= pwdata;
            err_q      <= setup_err;
`ifdef APB_WAIT_STATE_EN
            wait_cnt_q <= 4'(WAIT_EFF);
`endif
            if (ZERO_WAIT) begin
                pready_q  <= 1'b1;
                pslverr_q <= setup_err;
                prdata_q  <= (!pwrite && !setup_err) ? rd_data : '0;
            end else begin
                pready_q  <= 1'b0;
                pslverr_q <= 1'b0;
                prdata_q  <= '0;
            end
        end else if (state_q == ACCESS) begin
            if (!psel || (penable && pready_q)) begin
                // Either the requester abandoned the transfer or it completed this cycle.
                state_q   <= IDLE;
                pready_q  <= 1'b0;
                pslverr_q <= 1'b0;
                prdata_q  <= '0;
            end
`ifdef APB_WAIT_STATE_EN
            else if (wait_cnt_q > 4'd1) begin
                wait_cnt_q <= wait_cnt_q - 4'd1;
            end else begin
                pready_q  <= 1'b1;
                pslverr_q <= err_q;
                prdata_q  <= (!wr_q && !err_q) ? rd_data : '0;
            end
`endif
        end
    end

    assign pready  = pready_q;
    assign pslverr = pslverr_q;
    assign prdata  = prdata_q;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Randomised self-checking bench for apb_slave_mem.
// Expected outputs come from a memory array plus transfer timing. In the
// first access cycle after setup, pready rises on the (W+1)-th access cycle.
module tb_apb_slave_mem;

    localparam int AW = 8, DW = 8, DEPTH = 64;
`ifdef APB_WAIT_STATE_EN
    localparam int W = 2;
`else
    localparam int W = 0;
`endif

    logic          pclk = 1'b0, preset, psel, penable, pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata, prdata;
    logic          pready, pslverr;

    apb_slave_mem #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .WAIT_CYCLES(2)) dut (
        .pclk(pclk), .preset(preset), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pready(pready), .prdata(prdata), .pslverr(pslverr)
    );

    always #5 pclk = ~pclk;

    int            checks = 0, errors = 0;
    logic [DW-1:0] mem [DEPTH];
    logic          chk_en = 1'b0;
    logic          exp_rdy = 1'b0, exp_err = 1'b0;
    logic [DW-1:0] exp_rd = '0;
    logic [DW-1:0] obs_rd;
    logic          obs_err, obs_rdy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, req);
        end
    endtask

    // Every cycle, compare the registered outputs with the model's expectation.
    always @(negedge pclk) begin
        if (chk_en) begin
            chk("pready", {31'b0, pready}, {31'b0, exp_rdy});
            chk("prdata", {24'b0, prdata}, {24'b0, exp_rd});
            chk("pslverr", {31'b0, pslverr}, {31'b0, exp_err});
        end
    end

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic exp_zero();
        exp_rdy = 1'b0; exp_err = 1'b0; exp_rd = '0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            psel = 1'b0; penable = 1'b0;
            tick();
        end
    endtask

    // mode: 0 = normal, 1 = psel dropped, 2 = preset pulsed, 3 = new setup (nw/na/nd)
    // applied during access cycle k.
    task automatic xfer(input logic w, input logic [7:0] a, input logic [7:0] d,
                        input int mode, input int k,
                        input logic nw, input logic [7:0] na, input logic [7:0] nd);
        logic cw, last, err;
        logic [7:0] ca, cd;
        int m;
        cw = w; ca = a; cd = d; m = mode;
        psel = 1'b1; penable = 1'b0; pwrite = cw; paddr = ca; pwdata = cd;
        tick();
        for (int c = 1; c <= W + 1; c++) begin
            last = (c == W + 1);
            err  = (ca >= 8'(DEPTH));
            exp_rdy = last;
            exp_err = last && err;
            exp_rd  = (last && !cw && !err) ? mem[ca[5:0]] : '0;
            if (last) begin
                obs_rd = prdata; obs_err = pslverr; obs_rdy = pready;
            end
            psel = 1'b1; penable = 1'b1;
            if (m != 0 && c == k) begin
                if (m == 1) begin
                    psel = 1'b0; penable = 1'b0;
                end else if (m == 2) begin
                    preset = 1'b1;
                end else begin
                    penable = 1'b0; pwrite = nw; paddr = na; pwdata = nd;
                end
                tick();
                preset = 1'b0;
                if (m == 2) begin
                    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
                    psel = 1'b0; penable = 1'b0;
                end
                if (m != 3) begin
                    exp_zero();
                    return;
                end
                // The re-setup cycle was just consumed; run the new transfer from its first access cycle.
                cw = nw; ca = na; cd = nd; m = 0; c = 0;
                if (W == 0) continue;
                exp_zero();
                continue;
            end
            tick();
        end
        if (cw && ca < 8'(DEPTH)) mem[ca[5:0]] = cd;
        exp_zero();
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        xfer(1'b1, a, d, 0, 0, 1'b0, 8'h0, 8'h0);
    endtask

    task automatic rd(input logic [7:0] a);
        xfer(1'b0, a, 8'h0, 0, 0, 1'b0, 8'h0, 8'h0);
    endtask

    initial begin
        logic [7:0] ra, rdd;
        int r, md, kk;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
        tick();
        chk_en = 1'b1;
        idle(2);
        preset = 1'b0;
        idle(1);

        // Basic write then read-back.
        wr(8'h05, 8'hA5); rd(8'h05);
        chk("rd05_data", {24'b0, obs_rd}, 32'hA5);
        chk("rd05_err", {31'b0, obs_err}, 32'h0);
        chk("rd05_rdy", {31'b0, obs_rdy}, 32'h1);
        idle(1);
        wr(8'h10, 8'h3C); idle(1); rd(8'h10);
        chk("rd10_data", {24'b0, obs_rd}, 32'h3C);

        // Out-of-range write must not alias onto word 0.
        wr(8'h40, 8'hFF);
        chk("wr40_err", {31'b0, obs_err}, 32'h1);
        rd(8'h00);
        chk("rd00_data", {24'b0, obs_rd}, 32'h00);
        rd(8'h7F);
        chk("rd7f_err", {31'b0, obs_err}, 32'h1);
        chk("rd7f_data", {24'b0, obs_rd}, 32'h00);
        idle(1);

        // Reset during the second wait cycle aborts the write and wipes memory.
        xfer(1'b1, 8'h08, 8'h11, 2, (W >= 2) ? 2 : 1, 1'b0, 8'h0, 8'h0);
        idle(1);
        rd(8'h08);
        chk("rd08_after_rst", {24'b0, obs_rd}, 32'h00);
        rd(8'h05);
        chk("rd05_after_rst", {24'b0, obs_rd}, 32'h00);

        // An abandoned write leaves memory untouched.
        xfer(1'b1, 8'h02, 8'h77, 1, 1, 1'b0, 8'h0, 8'h0);
        idle(1);
        rd(8'h02);
        chk("rd02_abandon", {24'b0, obs_rd}, 32'h00);

        // Back-to-back writes.
        wr(8'h01, 8'h5A); wr(8'h02, 8'h6B); rd(8'h01);
        chk("b2b_01", {24'b0, obs_rd}, 32'h5A);
        rd(8'h02);
        chk("b2b_02", {24'b0, obs_rd}, 32'h6B);

        // A new setup mid-access drops the old write and runs the new read.
        xfer(1'b1, 8'h01, 8'hEE, 3, 1, 1'b0, 8'h02, 8'h00);
        chk("resetup_rd", {24'b0, obs_rd}, 32'h6B);
        rd(8'h01);
        chk("resetup_nowr", {24'b0, obs_rd}, 32'h5A);
        idle(1);

        // Randomised traffic.
        for (int it = 0; it < 400; it++) begin
            ra  = ($urandom % 8 == 0) ? 8'($urandom) : 8'($urandom_range(0, 79));
            rdd = 8'($urandom);
            r   = int'($urandom % 20);
            md  = (r < 14) ? 0 : (r < 17) ? 1 : (r == 17) ? 2 : 3;
            kk  = int'($urandom_range(1, W + 1));
            xfer(1'($urandom), ra, rdd, md, kk, 1'($urandom),
                 8'($urandom_range(0, 79)), 8'($urandom));
            if ($urandom % 2 == 0) idle(int'($urandom_range(1, 2)));
        end
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/apb_slave_mem.md
Name: apb_slave_mem

Overview:
APB completer (slave) with an internal register-file memory. It answers the APB requester that drives transfer/read_write toward the bus. It decodes psel/penable, performs reads and writes on local storage, inserts a fixed number of wait states and flags out-of-range accesses with pslverr. Two instances sit behind the requester, one per slave select.

Parameters:
AW, `AW, bus address width; only the low $clog2(DEPTH) bits index the memory.
DW, `DW, data width.
DEPTH, 64, number of DW-bit words; must be at most 2**AW.
WAIT_CYCLES, 2, access-phase wait states per transfer (0..15); honoured only with APB_WAIT_STATE_EN.

Ports:
pclk     input   1   clock; all logic on posedge.
preset   input   1   reset; synchronous and active-high.
psel     input   1   slave select from the requester.
penable  input   1   access phase indicator.
pwrite   input   1   1 = write, 0 = read.
paddr    input   AW  transfer address.
pwdata   input   DW  write data.
pready   output  1   transfer completes this cycle (registered).
prdata   output  DW  read data; valid only while pready=1 and pwrite=0 (registered).
pslverr  output  1   error response; valid only while pready=1 (registered).

Behaviour:
- Reset: preset=1 at a posedge sets state=IDLE, pready=0, prdata=0, pslverr=0, wait_cnt=0, and clears all memory words to 0. Reset overrides every other event.
- Mid-transfer reset aborts the transfer. No write is committed.
- FSM states: IDLE, ACCESS.
- IDLE:
  - On psel=1 && penable=0 (setup), latch paddr/pwrite/pwdata into addr_q/wr_q/wdata_q.
  - Compute err_q = (paddr >= DEPTH).
  - Load wait_cnt=WAIT_CYCLES and go to ACCESS.
  - If WAIT_CYCLES==0, also set pready<=1 on this edge (zero-wait: pready is high in the first access cycle).
- ACCESS with psel=1 && penable=1:
  - If pready=0 and wait_cnt>1: decrement wait_cnt.
  - If pready=0 and wait_cnt==1: set pready<=1, pslverr<=err_q, prdata<=(read && !err_q) ? mem[addr_q] : 0.
  - If pready=1 (completion edge): commit mem[addr_q]<=wdata_q if wr_q && !err_q. Then pready<=0, pslverr<=0, prdata<=0, go to IDLE.
- Read data and pslverr are loaded together with pready, on the same edge. The zero-wait path loads them at the setup edge.
- Latency: setup-to-completion is 2 + WAIT_CYCLES cycles, including the setup cycle.
- ACCESS with psel=0 (requester abandons the transfer): return to IDLE, clear pready/pslverr/prdata, no write.
- ACCESS with psel=1 && penable=0 (protocol violation, new setup): treat as a fresh setup and relatch the new transfer as in IDLE. The old transfer is dropped.
- Errored write: pready and pslverr high for one cycle; memory unchanged.
- Errored read: prdata=0.
- Back-to-back transfers: the requester issues setup the cycle after completion. The FSM is in IDLE then, so there is no bubble beyond the APB setup cycle.
- pready is never high in IDLE. pslverr and prdata are 0 whenever pready=0.
- Address index is addr_q[$clog2(DEPTH)-1:0]. Range check uses the full AW bits.

Optional Feature:
APB_WAIT_STATE_EN:
- Defined: wait_cnt counter is present and WAIT_CYCLES is honoured as above.
- Undefined: counter removed, WAIT_CYCLES ignored, and the slave always behaves as WAIT_CYCLES=0. pready is set at every setup edge, giving a 2-cycle transfer.

Decomposition:
- Shared package apb_pkg holds:
  - typedef enum logic {IDLE, ACCESS} apb_slv_state_e
  - typedef logic [`AW-1:0] apb_addr_t
  - typedef logic [`DW-1:0] apb_data_t
  - localparam APB_MAX_WAIT=15
- One sub-module, apb_slave_regfile: DEPTH x DW storage with synchronous write, combinational read and synchronous clear on preset.
- FSM, counter and response registers stay in apb_slave_mem.

Test Plan:
- WAIT_CYCLES=0, write addr 0x05 data 0xA5, then read addr 0x05 -> each transfer completes in 2 cycles, pready high in the access cycle, read returns prdata=0xA5, pslverr=0.
- WAIT_CYCLES=2 with APB_WAIT_STATE_EN, read addr 0x10 after writing 0x3C -> pready low for 2 access cycles, then high for 1; prdata=0x3C only in that cycle.
- Write addr 0x40 (DEPTH=64) data 0xFF -> pready=1, pslverr=1 for one cycle; a read of addr 0x00 afterwards is unchanged.
- Read addr 0x7F -> pslverr=1, prdata=0x00.
- preset asserted in the second wait cycle of a write to 0x08 data 0x11 -> next cycle outputs are 0, state IDLE, a read of 0x08 returns 0x00.
- psel dropped mid-ACCESS on a write to 0x02 data 0x77 -> no pready pulse, mem[0x02] stays 0.
- Back-to-back writes to 0x01 and 0x02 -> both committed, no extra idle cycle between transfers.
